spi_slave_wb: RTL and testbench

WISHBONE SPI responder for the Lattuino SoC: lets an external SPI master (host MCU, bridge, ISP adapter) exchange bytes with the AVR core through the ARDU10..13 pins. Sits on the WISHBONE intercon beside UART, timers and A/D. Features an 8-bit data register with single TX/RX holding buffers and status/control registers. Interrupt request/ack pair matches the device-IRQ scheme used by the 16-bit timer.

---
 rtl/spi_slave_pkg.sv | 25 ++
 rtl/spis_sync.sv | 25 ++
 rtl/spi_slave_wb.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_wb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants for the WISHBONE SPI responder: register map, STATUS/CTRL
// bit positions and FSM state encoding.
package spi_slave_pkg;

  localparam logic [1:0] SPIS_ADR_DATA   = 2'd0;
  localparam logic [1:0] SPIS_ADR_STATUS = 2'd1;
  localparam logic [1:0] SPIS_ADR_CTRL   = 2'd2;

  localparam int STAT_RXF  = 0;
  localparam int STAT_TXE  = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_UDR  = 3;
  localparam int STAT_BUSY = 4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_RXIE = 1;
  localparam int CTRL_TXIE = 2;
  localparam int CTRL_CPOL = 3;
  localparam int CTRL_CPHA = 4;

  typedef logic [0:0] spis_state_t;
  localparam spis_state_t SPIS_IDLE  = 1'b0;
  localparam spis_state_t SPIS_SHIFT = 1'b1;

endpackage

// File: rtl/spis_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a third stage
// that provides single-cycle rise/fall pulses on the synchronized copy.
module spis_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RST_VAL}};
    else        sync_q <= {sync_q[1:0], d};
  end

  assign q    = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_wb.sv
// WISHBONE SPI responder with single TX/RX holding buffers and a latched IRQ.
// Define SPI_SLAVE_MODE_SEL_EN to make CPOL/CPHA writable (modes 0-3); otherwise mode 0 only.
module spi_slave_wb
  import spi_slave_pkg::*;
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  output logic       wb_ack_o,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic       irq_req_o,
  input  logic       irq_ack_i
);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q;
  logic [1:0] mosi_edge_unused;

  spis_sync #(.RST_VAL(1'b0)) u_sck (
    .clk_sys(wb_clk_i), .rst_n(wb_rst_n_i), .d(sck_i),
    .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spis_sync #(.RST_VAL(1'b1)) u_ss (
    .clk_sys(wb_clk_i), .rst_n(wb_rst_n_i), .d(ss_n_i),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );
  spis_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk_sys(wb_clk_i), .rst_n(wb_rst_n_i), .d(mosi_i),
    .q(mosi_q), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
  );

  logic en, rxie, txie, cpol, cpha;
  logic rxf, txe, ovr, udr;
  logic [7:0] tx_buf, rx_buf, tx_sr, rx_sr;
  logic [2:0] bit_cnt;
  spis_state_t state;

  logic data_wr, data_rd, stat_wr, ctrl_wr;
  logic leading, trailing, sample_edge, shift_edge;
  logic start, byte_done, tx_load, tx_take, rx_take;
  logic [7:0] rx_byte, status_byte, ctrl_byte;

  assign data_wr = wb_stb_i & wb_we_i & (wb_adr_i == SPIS_ADR_DATA);
  assign data_rd = wb_stb_i & ~wb_we_i & (wb_adr_i == SPIS_ADR_DATA);
  assign stat_wr = wb_stb_i & wb_we_i & (wb_adr_i == SPIS_ADR_STATUS);
  assign ctrl_wr = wb_stb_i & wb_we_i & (wb_adr_i == SPIS_ADR_CTRL);

  assign leading     = cpol ? sck_fall : sck_rise;
  assign trailing    = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trailing : leading;
  assign shift_edge  = cpha ? leading : trailing;

  // A byte boundary and a transfer start both pull the next TX byte.
  assign start     = (state == SPIS_IDLE) & en & ss_fall;
  assign byte_done = (state == SPIS_SHIFT) & en & ~ss_rise & sample_edge & (bit_cnt == 3'd7);
  assign tx_load   = start | byte_done;
  assign tx_take   = tx_load & ~txe;
  assign rx_take   = byte_done & (~rxf | data_rd);
  assign rx_byte   = {rx_sr[6:0], mosi_q};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      en   <= 1'b0;
      rxie <= 1'b0;
      txie <= 1'b0;
    end else if (ctrl_wr) begin
      en   <= wb_dat_i[CTRL_EN];
      rxie <= wb_dat_i[CTRL_RXIE];
      txie <= wb_dat_i[CTRL_TXIE];
    end
  end

`ifdef SPI_SLAVE_MODE_SEL_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cpol <= 1'b0;
      cpha <= 1'b0;
    end else if (ctrl_wr) begin
      cpol <= wb_dat_i[CTRL_CPOL];
      cpha <= wb_dat_i[CTRL_CPHA];
    end
  end
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  // The opposite edge never shifts right after a byte boundary (bit_cnt==0):
  // in CPHA=1 the first leading edge only presents bit 7, in CPHA=0 the
  // freshly reloaded byte must survive the trailing edge of the last bit.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state   <= SPIS_IDLE;
      bit_cnt <= 3'd0;
      tx_sr   <= 8'h00;
      rx_sr   <= 8'h00;
    end else if (state == SPIS_IDLE) begin
      if (start) begin
        state   <= SPIS_SHIFT;
        bit_cnt <= 3'd0;
        tx_sr   <= txe ? 8'hFF : tx_buf;
      end
    end else if (!en || ss_rise) begin
      state   <= SPIS_IDLE;
      bit_cnt <= 3'd0;
    end else if (sample_edge) begin
      rx_sr   <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) tx_sr <= txe ? 8'hFF : tx_buf;
    end else if (shift_edge && bit_cnt != 3'd0) begin
      tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  // Later assignments win, so SPI-side set events override CPU clears.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rxf       <= 1'b0;
      txe       <= 1'b1;
      ovr       <= 1'b0;
      udr       <= 1'b0;
      tx_buf    <= 8'h00;
      rx_buf    <= 8'h00;
      irq_req_o <= 1'b0;
    end else begin
      if (data_rd) rxf <= 1'b0;
      if (data_wr) tx_buf <= wb_dat_i;
      if (data_wr) txe <= 1'b0;
      else if (tx_take) txe <= 1'b1;
      if (stat_wr && wb_dat_i[STAT_OVR]) ovr <= 1'b0;
      if (stat_wr && wb_dat_i[STAT_UDR]) udr <= 1'b0;
      if (rx_take) begin
        rx_buf <= rx_byte;
        rxf    <= 1'b1;
      end else if (byte_done) begin
        ovr <= 1'b1;
      end
      if (tx_load && txe) udr <= 1'b1;
      if (irq_ack_i) irq_req_o <= 1'b0;
      if ((rx_take && rxie) || (tx_take && txie)) irq_req_o <= 1'b1;
    end
  end

  always_comb begin
    status_byte            = 8'h00;
    status_byte[STAT_RXF]  = rxf;
    status_byte[STAT_TXE]  = txe;
    status_byte[STAT_OVR]  = ovr;
    status_byte[STAT_UDR]  = udr;
    status_byte[STAT_BUSY] = ~ss_q;
    ctrl_byte              = 8'h00;
    ctrl_byte[CTRL_EN]     = en;
    ctrl_byte[CTRL_RXIE]   = rxie;
    ctrl_byte[CTRL_TXIE]   = txie;
    ctrl_byte[CTRL_CPOL]   = cpol;
    ctrl_byte[CTRL_CPHA]   = cpha;
  end

  always_comb begin
    wb_dat_o = 8'h00;
    if (wb_stb_i) begin
      case (wb_adr_i)
        SPIS_ADR_DATA:   wb_dat_o = rx_buf;
        SPIS_ADR_STATUS: wb_dat_o = status_byte;
        SPIS_ADR_CTRL:   wb_dat_o = ctrl_byte;
        default:         wb_dat_o = 8'h00;
      endcase
    end
  end

  assign wb_ack_o  = wb_stb_i;
  assign miso_o    = tx_sr[7];
  assign miso_oe_o = en & ~ss_q;

endmodule

// File: tb/tb_spi_slave_wb.sv
// Scoreboard bench for spi_slave_wb: directed SPI/WISHBONE vectors, expected
// values queued at stimulus time and checked by separate monitor processes.
module tb_spi_slave_wb;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] adr = 2'd0;
  logic [7:0] dat_w = 8'h00;
  logic [7:0] dat_r;
  logic       we = 1'b0;
  logic       stb = 1'b0;
  logic       ack;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, irq_req;
  logic       irq_ack = 1'b0;

  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] master_rx;
  event       master_done;

  typedef struct {
    string      name;
    logic [7:0] data;
  } exp_t;

  exp_t       wb_q[$];
  logic [7:0] miso_q[$];

  int n_checks = 0;
  int n_pass = 0;

  spi_slave_wb dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_dat_o(dat_r), .wb_we_i(we), .wb_stb_i(stb), .wb_ack_o(ack),
    .sck_i(sck), .ss_n_i(ss_n), .mosi_i(mosi), .miso_o(miso),
    .miso_oe_o(miso_oe), .irq_req_o(irq_req), .irq_ack_i(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    adr = a; dat_w = d; we = 1'b1; stb = 1'b1;
    @(posedge clk); #2;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.data = exp;
    wb_q.push_back(e);
    @(posedge clk); #2;
    adr = a; we = 1'b0; stb = 1'b1;
    @(posedge clk); #2;
    stb = 1'b0;
  endtask

  // Read-data monitor: every completed read strobe consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stb && ack && !we) begin
        if (wb_q.size() == 0) check_output("wb_unexpected_read", 1, 0);
        else begin
          e = wb_q.pop_front();
          check_output(e.name, dat_r, e.data);
        end
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(master_done);
      if (miso_q.size() == 0) check_output("miso_unexpected", 1, 0);
      else begin
        e = miso_q.pop_front();
        check_output("miso_byte", master_rx, e);
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!m_cpha) begin
        mosi = tx[7-i];
        wait_clks(HALF);
        sck = ~m_cpol;
        rx[7-i] = miso;
        wait_clks(HALF);
        sck = m_cpol;
      end else begin
        sck = ~m_cpol;
        mosi = tx[7-i];
        wait_clks(HALF);
        sck = m_cpol;
        rx[7-i] = miso;
        wait_clks(HALF);
      end
    end
    if (!m_cpha) wait_clks(HALF);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] rx;
    miso_q.push_back(exp);
    spi_bits(tx, 8, rx);
    master_rx = rx;
    -> master_done;
  endtask

  task automatic ss_begin();
    ss_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic ss_end();
    wait_clks(4);
    ss_n = 1'b1;
    wait_clks(12);
  endtask

  task automatic wait_irq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (irq_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("irq_timeout", 0, 1);
  endtask

  task automatic pulse_ack();
    @(posedge clk); #2;
    irq_ack = 1'b1;
    @(posedge clk); #2;
    irq_ack = 1'b0;
    check_output("irq_cleared_by_ack", irq_req, 0);
  endtask

  task automatic apply_stimulus();
    logic [7:0] tx_bytes[4];
    logic [7:0] mo_bytes[3];
    logic [7:0] part_rx;
    bit ok;
    tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h4B; tx_bytes[2] = 8'hE1; tx_bytes[3] = 8'h00;
    mo_bytes[0] = 8'h12; mo_bytes[1] = 8'h34; mo_bytes[2] = 8'h56;

    // Mode 0 single byte
    wb_write(2'd2, 8'h01);
    wb_write(2'd0, 8'hA5);
    wb_read(2'd1, 8'h00, "status_tx_loaded");
    ss_begin();
    spi_byte(8'h3C, 8'hA5);
    ss_end();
    wb_read(2'd1, 8'h0B, "status_after_byte");
    wb_read(2'd0, 8'h3C, "data_single");
    wb_read(2'd1, 8'h0A, "status_rxf_cleared");
    wb_write(2'd1, 8'h08);
    wb_read(2'd1, 8'h02, "status_udr_cleared");

    // Back-to-back bytes, TX buffer refilled from the TXIE interrupt
    wb_write(2'd2, 8'h05);
    wb_write(2'd0, tx_bytes[0]);
    fork
      begin
        ss_begin();
        for (int i = 0; i < 3; i++) spi_byte(mo_bytes[i], tx_bytes[i]);
        ss_end();
      end
      begin
        for (int k = 0; k < 4; k++) begin
          wait_irq(ok);
          if (!ok) break;
          pulse_ack();
          if (k > 0) wb_read(2'd0, mo_bytes[k-1], "data_b2b");
          if (k < 3) wb_write(2'd0, tx_bytes[k+1]);
        end
      end
    join
    wb_read(2'd1, 8'h02, "status_b2b_no_udr");
    check_output("irq_idle_after_b2b", irq_req, 0);

    // Overrun
    wb_write(2'd2, 8'h01);
    ss_begin(); spi_byte(8'h11, 8'hFF); ss_end();
    ss_begin(); spi_byte(8'h22, 8'hFF); ss_end();
    wb_read(2'd1, 8'h0F, "status_overrun");
    wb_write(2'd1, 8'h04);
    wb_read(2'd1, 8'h0B, "status_ovr_cleared");
    wb_read(2'd0, 8'h11, "data_overrun_keeps_first");
    wb_write(2'd1, 8'h08);

    // Underrun
    ss_begin(); spi_byte(8'h69, 8'hFF); ss_end();
    wb_read(2'd1, 8'h0B, "status_underrun");
    wb_read(2'd0, 8'h69, "data_underrun");
    wb_write(2'd1, 8'h08);

    // SS abort after 5 bits, then a full byte
    wb_write(2'd0, 8'h77);
    ss_begin(); spi_bits(8'hF0, 5, part_rx); ss_end();
    wb_read(2'd1, 8'h02, "status_after_abort");
    ss_begin(); spi_byte(8'h81, 8'hFF); ss_end();
    wb_read(2'd1, 8'h0B, "status_after_abort_byte");
    wb_read(2'd0, 8'h81, "data_after_abort");
    wb_write(2'd1, 8'h08);

    // CTRL readback of mode bits
    wb_write(2'd2, 8'h1F);
`ifdef SPI_SLAVE_MODE_SEL_EN
    wb_read(2'd2, 8'h1F, "ctrl_readback");
`else
    wb_read(2'd2, 8'h07, "ctrl_readback");
`endif
    wb_write(2'd2, 8'h01);

`ifdef SPI_SLAVE_MODE_SEL_EN
    for (int m = 1; m < 4; m++) begin
      m_cpol = (m >= 2);
      m_cpha = (m % 2 == 1);
      sck = m_cpol;
      wait_clks(6);
      wb_write(2'd2, {3'b000, m_cpha, m_cpol, 3'b001});
      wb_write(2'd0, 8'h5A);
      ss_begin(); spi_byte(8'hC3, 8'h5A); ss_end();
      wb_read(2'd0, 8'hC3, "data_mode_n");
      wb_write(2'd1, 8'h08);
    end
    m_cpol = 1'b0;
    m_cpha = 1'b0;
    sck = 1'b0;
    wb_write(2'd2, 8'h01);
    wait_clks(6);
`endif

    // Asynchronous reset in the middle of a byte
    wb_write(2'd2, 8'h05);
    wb_write(2'd0, 8'h3C);
    ss_begin();
    check_output("irq_on_tx_load", irq_req, 1);
    check_output("oe_while_selected", miso_oe, 1);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      wait_clks(HALF);
      sck = 1'b1;
      wait_clks(HALF);
      sck = 1'b0;
    end
    wait_clks(HALF);
    check_output("miso_mid_byte", miso, 1);
    @(posedge clk); #6;
    adr = 2'd2; we = 1'b0; stb = 1'b1;
    #1;
    check_output("ctrl_before_reset", dat_r, 8'h05);
    rst_n = 1'b0;
    #1;
    check_output("rst_async_miso", miso, 0);
    check_output("rst_async_oe", miso_oe, 0);
    check_output("rst_async_irq", irq_req, 0);
    check_output("rst_async_dat", dat_r, 0);
    #1;
    stb = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(5);
    wb_read(2'd1, 8'h02, "status_after_reset2");
    wb_read(2'd2, 8'h00, "ctrl_after_reset2");
  endtask

  initial begin
    wait_clks(4);
    check_output("reset_miso", miso, 0);
    check_output("reset_oe", miso_oe, 0);
    check_output("reset_irq", irq_req, 0);
    check_output("reset_dat", dat_r, 0);
    rst_n = 1'b1;
    wait_clks(4);
    wb_read(2'd1, 8'h02, "status_reset");
    wb_read(2'd2, 8'h00, "ctrl_reset");

    apply_stimulus();

    wait_clks(10);
    check_output("wb_queue_drained", wb_q.size(), 0);
    check_output("miso_queue_drained", miso_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
